// File: rtl/mem_bus_responder.sv
// Word-organised single-port memory responder for a level-held read/write request bus with a one-cycle ack.
// Define MEM_BUS_RESPONDER_RANDOM_WAIT_EN to add an LFSR-driven random term (0..3) to the wait count.
module mem_bus_responder #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        mem_err,
    output logic        busy
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_GAP} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic        rd_reg, rd_next;
    logic        wr_reg, wr_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] rdata_reg;
    logic        ack_reg, err_reg, busy_reg;
    logic [4:0]  wait_cnt;

    logic [31:0] mem [DEPTH];

`ifdef MEM_BUS_RESPONDER_RANDOM_WAIT_EN
    logic [7:0] lfsr_reg, lfsr_next;
    assign wait_cnt = 5'(WAIT_CYCLES) + {3'b000, lfsr_reg[1:0]};
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign wait_cnt    = 5'(WAIT_CYCLES);
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rd_next    = rd_reg;
        wr_next    = wr_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
`ifdef MEM_BUS_RESPONDER_RANDOM_WAIT_EN
        lfsr_next  = lfsr_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    rd_next    = mem_read;
                    wr_next    = mem_write;
                    addr_next  = mem_addr;
                    wdata_next = mem_wdata;
                    cnt_next   = wait_cnt;
`ifdef MEM_BUS_RESPONDER_RANDOM_WAIT_EN
                    lfsr_next  = {lfsr_reg[6:0],
                                  lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
`endif
                    state_next = (wait_cnt == 5'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 5'd1;
                if (cnt_reg <= 5'd1) begin
                    state_next = S_ACK;
                end
            end
            S_ACK:   state_next = S_GAP;
            default: state_next = S_IDLE;
        endcase
    end

    // Access happens on the edge that enters ACK; the *_next values equal the live
    // bus when accepting straight from IDLE and the latched copy otherwise.
    logic            acc;
    logic            acc_err;
    logic [31:0]     offset;
    logic [AW-1:0]   idx;

    assign acc     = (state_next == S_ACK) && (state_reg != S_ACK);
    assign offset  = addr_next - BASE_ADDR;
    assign idx     = offset[AW+1:2];
    assign acc_err = (offset[1:0] != 2'b00) || ({1'b0, offset} >= SPAN) || (rd_next && wr_next);

    // Array has no reset; gate with rst so a held request cannot write while in reset.
    always_ff @(posedge clk) begin
        if (!rst && acc && wr_next && !acc_err) begin
            mem[idx] <= wdata_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 5'd0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
`ifdef MEM_BUS_RESPONDER_RANDOM_WAIT_EN
            lfsr_reg  <= LFSR_SEED;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rd_reg    <= rd_next;
            wr_reg    <= wr_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            ack_reg   <= acc;
            err_reg   <= acc && acc_err;
            busy_reg  <= (state_next != S_IDLE);
`ifdef MEM_BUS_RESPONDER_RANDOM_WAIT_EN
            lfsr_reg  <= lfsr_next;
`endif
            if (acc) begin
                if (acc_err) begin
                    rdata_reg <= 32'd0;
                end else if (rd_next) begin
                    rdata_reg <= mem[idx];
                end
            end
        end
    end

    assign mem_rdata = rdata_reg;
    assign mem_ack   = ack_reg;
    assign mem_err   = err_reg;
    assign busy      = busy_reg;
endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Single-port, word-organised memory responder. It is the target end of the core's memory request interface: level-held `mem_read`/`mem_write`, answered with a one-cycle `mem_ack`. It serves the MEM-stage path and the atomic sequencer (LR/SC/AMO read-modify-write) in core-level simulation and in small on-chip RAM instances. Wait states are programmable, and address/alignment errors are flagged, so initiator stall and handshake logic can be exercised.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words. Power of two, ≥ 4.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0. Must be `DEPTH*4`-aligned.
- `WAIT_CYCLES`, 0: fixed wait states inserted before ack, 0..15.
- `LFSR_SEED`, 8'hA5: non-zero seed for the random-wait LFSR. Used only with the macro defined.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `mem_read`, in, 1: read request, held by the initiator until ack.
- `mem_write`, in, 1: write request, held by the initiator until ack.
- `mem_addr`, in, 32: byte address. Must be stable while a request is held.
- `mem_wdata`, in, 32: write data. Must be stable while a request is held.
- `mem_rdata`, out, 32: read data. Valid in the `mem_ack` cycle.
- `mem_ack`, out, 1: one-cycle completion pulse. Registered.
- `mem_err`, out, 1: error qualifier. High only together with `mem_ack`.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, WAIT, ACK, GAP. All outputs are registered.
- Reset values: state IDLE, `mem_ack`=0, `mem_err`=0, `mem_rdata`=0, `busy`=0, wait counter 0, LFSR=`LFSR_SEED`. Array contents are not reset.
- **IDLE**: on a sampled edge with `mem_read|mem_write`:
  - Latch op, address and wdata.
  - Load the wait counter with the wait count (`WAIT_CYCLES`, plus a random term when the macro is defined).
  - If the wait count is 0, go to ACK; otherwise go to WAIT.
- **WAIT**: decrement the counter each cycle. When the counter reaches 1, go to ACK.
  - Live bus inputs are ignored; only the latched values are used.
- **Entering ACK** (same edge): perform the access.
  - Read: `mem_rdata` ← `mem[idx]`.
  - Write: `mem[idx]` ← wdata, and `mem_rdata` keeps its previous value.
  - `mem_ack` is set to 1 for exactly one cycle.
- **ACK → GAP → IDLE**: GAP lasts one cycle and ignores requests. This gives the initiator one cycle to deassert or change its request after the ack before the responder samples again.
- Index: `idx = (mem_addr - BASE_ADDR) >> 2`, using `$clog2(DEPTH)` bits.
- Errors: `mem_err`=1 in the ACK cycle, with no array write and `mem_rdata`=0, when any of these hold:
  - `mem_addr[1:0] != 0`;
  - the address lies outside `[BASE_ADDR, BASE_ADDR+DEPTH*4)`;
  - `mem_read` and `mem_write` were both high at acceptance.
- A write followed by a read to the same word returns the new data; there are no bypass hazards.
- `mem_rdata` holds its last value outside ack cycles. Initiators must sample it only when `mem_ack` is high.

## Timing
- Latency is `W+1` cycles, where W is the effective wait count. Example: with the request first sampled at edge k, `mem_ack` is high in the cycle after edge k+W.
- W=0 gives ack in the cycle following acceptance.
- Minimum request spacing is W+3 cycles (IDLE, ACK, GAP).
- A request dropped during WAIT still completes: the latched op is executed and acked.
- Reset mid-operation, including in WAIT or ACK: return to IDLE immediately and drop the ack.
  - A write is committed only on the ACK-entry edge. If reset precedes that edge, no array update occurs.
- Requests arriving in ACK or GAP are not accepted until IDLE. A held request is then accepted on the first IDLE edge.

## Configuration
- `MEM_BUS_RESPONDER_RANDOM_WAIT_EN` defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded with `LFSR_SEED`, advances once per accepted request.
  - Effective wait count W = `WAIT_CYCLES` + `lfsr[1:0]`, with the value sampled at acceptance.
- Not defined:
  - No LFSR logic is instantiated.
  - W = `WAIT_CYCLES` for every request, giving deterministic latency.

## Test plan
- Write then read (WAIT_CYCLES=0): write 32'hDEAD_BEEF to 0x10, then read 0x10. Each ack comes 1 cycle after acceptance, and the read returns 32'hDEAD_BEEF with `mem_err`=0.
- WAIT_CYCLES=3: read 0x0. `mem_ack` is high in exactly 1 cycle, 4 cycles after acceptance; `busy` is high from acceptance through GAP.
- Error cases: read 0x2 (misaligned), read `BASE_ADDR+DEPTH*4` (out of range), and simultaneous read+write to 0x8. Each acks with `mem_err`=1 and `mem_rdata`=0, and word 0x8 is unchanged.
- AMO-style sequence: read 0x20 (holding 5), then write 6 to 0x20, with the request held through ack and reasserted in GAP. The second request is accepted only in IDLE, and a later read of 0x20 returns 6.
- Reset during WAIT of a write of 32'h1234 to 0x30 (WAIT_CYCLES=4, `rst` asserted at cycle 2): no ack, FSM in IDLE, and 0x30 keeps its prior value.
- Random-wait build (`LFSR_SEED`=8'hA5): 16 back-to-back reads. Each ack latency is in [`WAIT_CYCLES`+1, `WAIT_CYCLES`+4], and the latencies match the LFSR reference model.
